// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with KMP fallback.
// Consumes one bit per in_valid cycle and pulses 'out' for one cycle, one
// cycle after the bit that completes PATTERN (MSB received first).
// OVERLAP=1 keeps the longest proper border after a match; OVERLAP=0
// restarts from an empty prefix.
// Optional feature macro: SEQDET_COUNT_EN adds a saturating match counter
// and the match_count port.
// Handshake: i is consumed on a rising clk edge only when in_valid=1 and
// rst=0; there is no back-pressure, every valid bit is accepted.
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i,
    input  logic                     in_valid,
    output logic                     out,
    output logic [$clog2(PAT_LEN)-1:0] p_dbg
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0]         match_count
`endif
);

    localparam int P_W = $clog2(PAT_LEN);
    localparam logic [P_W-1:0] LAST = P_W'(PAT_LEN - 1);

    // Longest PATTERN prefix (shorter than PAT_LEN) that is a suffix of
    // the first s pattern bits followed by bit b. For s=PAT_LEN-1 with a
    // matching b this is the longest proper border of PATTERN.
    function automatic int kmp_next(input int s, input logic b);
        logic [16:0] seq;
        int          len;
        int          res;
        logic        ok;
        seq = '0;
        for (int j = 0; j < 16; j++) begin
            if (j < s) begin
                seq[j] = PATTERN[PAT_LEN-1-j];
            end
        end
        seq[s] = b;
        len    = s + 1;
        res    = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= len && k < PAT_LEN) begin
                ok = 1'b1;
                for (int j = 0; j < 16; j++) begin
                    if (j < k) begin
                        if (PATTERN[PAT_LEN-1-j] != seq[len-k+j]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

    logic [P_W-1:0] nxt0 [PAT_LEN];
    logic [P_W-1:0] nxt1 [PAT_LEN];
    logic           pbit [PAT_LEN];

    // Transition table built at elaboration, one entry per progress state.
    for (genvar s = 0; s < PAT_LEN; s++) begin : g_tab
        localparam int N0 = kmp_next(s, 1'b0);
        localparam int N1 = kmp_next(s, 1'b1);
        assign nxt0[s] = P_W'(N0);
        assign nxt1[s] = P_W'(N1);
        assign pbit[s] = PATTERN[PAT_LEN-1-s];
    end

    logic [P_W-1:0] p;
    logic [P_W-1:0] p_next;
    logic           hit;

    // State register: progress p and the registered match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= '0;
            out <= 1'b0;
        end else begin
            p   <= p_next;
            out <= hit;
        end
    end

    // Next-state: follow the KMP table on consumed bits, hold otherwise.
    always_comb begin
        p_next = p;
        if (in_valid) begin
            if (hit && OVERLAP == 0) begin
                p_next = '0;
            end else if (i) begin
                p_next = nxt1[p];
            end else begin
                p_next = nxt0[p];
            end
        end
    end

    // Output decode: the consumed bit completes the pattern.
    always_comb begin
        hit = 1'b0;
        if (in_valid && p == LAST && i == pbit[p]) begin
            hit = 1'b1;
        end
    end

    assign p_dbg = p;

`ifdef SEQDET_COUNT_EN
    // Saturating match counter, stepping on the same edge that raises out.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count <= '0;
        end else if (hit && match_count != {CNT_W{1'b1}}) begin
            match_count <= match_count + 1'b1;
        end
    end
`endif

endmodule
